// File: rtl/ysyx_22041211_sram_slave.sv
// Word-addressed SRAM target for the core's fetch and load/store bus.
// Accepts one AXI4-Lite-subset transaction at a time (read or write, round-robin
// when both are pending), then answers after a programmable number of wait
// states, optionally stretched by an LFSR to shake out initiator timing bugs.
module ysyx_22041211_sram_slave #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH_LOG2 = 12,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h8000_0000,
  parameter int                    RD_LATENCY = 1,
  parameter int                    WR_LATENCY = 1,
  parameter bit                    RAND_EN    = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,

  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rvalid,
  input  logic                    rready,

  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready
);

  localparam int                    NUM_WORDS   = 1 << DEPTH_LOG2;
  localparam int                    STRB_W      = DATA_WIDTH / 8;
  localparam int                    CNT_W       = 16;
  localparam logic [ADDR_WIDTH-1:0] SPAN        = ADDR_WIDTH'(64'd4 << DEPTH_LOG2);
  localparam logic [1:0]            RESP_OKAY   = 2'b00;
  localparam logic [1:0]            RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_WAIT,
    S_RD_RESP,
    S_WR_WAIT,
    S_WR_RESP
  } state_e;

  typedef enum logic {
    GRANT_READ,
    GRANT_WRITE
  } grant_e;

  // Registered state
  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [7:0]            lfsr_q, lfsr_d;
  grant_e                last_grant_q, last_grant_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic                  rvalid_q, rvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  bvalid_q, bvalid_d;

  // Storage array
  logic [DATA_WIDTH-1:0] mem [NUM_WORDS];

  // Decode and arbitration
  logic [ADDR_WIDTH-1:0] rd_off, wr_off;
  logic                  rd_in_range, wr_in_range;
  logic [DEPTH_LOG2-1:0] rd_idx, wr_idx;
  logic                  rd_req, wr_req;
  logic                  grant_rd, grant_wr;
  logic                  ar_hs, w_hs;
  logic                  mem_we;
  logic [2:0]            extra;
  logic [CNT_W-1:0]      rd_load, wr_load;

  // Offsets are unsigned differences, so addresses below BASE_ADDR wrap to a
  // huge value and fall out of range along with addresses above the array.
  assign rd_off      = araddr - BASE_ADDR;
  assign wr_off      = awaddr - BASE_ADDR;
  assign rd_in_range = rd_off < SPAN;
  assign wr_in_range = wr_off < SPAN;
  assign rd_idx      = rd_off[DEPTH_LOG2+1:2];
  assign wr_idx      = wr_off[DEPTH_LOG2+1:2];

  // Address and data channels of a write are only accepted together.
  assign rd_req = arvalid;
  assign wr_req = awvalid & wvalid;

  // Round-robin grant: on contention the side that did not go last wins.
  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    grant_rd = 1'b0;
    grant_wr = 1'b0;
    if (rd_req && wr_req) begin
      grant_rd = (last_grant_q == GRANT_WRITE);
      grant_wr = (last_grant_q == GRANT_READ);
    end else begin
      grant_rd = rd_req;
      grant_wr = wr_req;
    end
  end

  // Readies are only offered in IDLE and are held low while reset is asserted.
  assign arready = rst & (state_q == S_IDLE) & grant_rd;
  assign awready = rst & (state_q == S_IDLE) & grant_wr;
  assign wready  = awready;

  assign ar_hs  = arvalid & arready;
  assign w_hs   = awvalid & awready & wvalid & wready;
  assign mem_we = w_hs & wr_in_range;

  // Wait-state load: the fixed latency minus the cycle spent entering the
  // response state, plus optional LFSR jitter sampled at the handshake.
  assign extra   = RAND_EN ? lfsr_q[2:0] : 3'd0;
  assign rd_load = CNT_W'(RD_LATENCY - 1) + CNT_W'(extra);
  assign wr_load = CNT_W'(WR_LATENCY - 1) + CNT_W'(extra);

  // Free-running 8-bit Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1.
  always_comb begin
    lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  // Transaction FSM: accept, wait, present response, retire.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    rdata_d      = rdata_q;
    rresp_d      = rresp_q;
    rvalid_d     = rvalid_q;
    bresp_d      = bresp_q;
    bvalid_d     = bvalid_q;

    case (state_q)
      S_IDLE: begin
        if (ar_hs) begin
          rdata_d      = rd_in_range ? mem[rd_idx] : '0;
          rresp_d      = rd_in_range ? RESP_OKAY : RESP_SLVERR;
          cnt_d        = rd_load;
          last_grant_d = GRANT_READ;
          if (rd_load == '0) begin
            state_d  = S_RD_RESP;
            rvalid_d = 1'b1;
          end else begin
            state_d  = S_RD_WAIT;
          end
        end else if (w_hs) begin
          bresp_d      = wr_in_range ? RESP_OKAY : RESP_SLVERR;
          cnt_d        = wr_load;
          last_grant_d = GRANT_WRITE;
          if (wr_load == '0) begin
            state_d  = S_WR_RESP;
            bvalid_d = 1'b1;
          end else begin
            state_d  = S_WR_WAIT;
          end
        end
      end

      S_RD_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d  = S_RD_RESP;
          rvalid_d = 1'b1;
        end
      end

      S_RD_RESP: begin
        if (rready) begin
          state_d  = S_IDLE;
          rvalid_d = 1'b0;
        end
      end

      S_WR_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d  = S_WR_RESP;
          bvalid_d = 1'b1;
        end
      end

      S_WR_RESP: begin
        if (bready) begin
          state_d  = S_IDLE;
          bvalid_d = 1'b0;
        end
      end

      default: begin
        state_d  = S_IDLE;
        rvalid_d = 1'b0;
        bvalid_d = 1'b0;
      end
    endcase
  end

  // Control and response registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      lfsr_q       <= 8'hA5;
      last_grant_q <= GRANT_WRITE;
      rdata_q      <= '0;
      rresp_q      <= RESP_OKAY;
      rvalid_q     <= 1'b0;
      bresp_q      <= RESP_OKAY;
      bvalid_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      lfsr_q       <= lfsr_d;
      last_grant_q <= last_grant_d;
      rdata_q      <= rdata_d;
      rresp_q      <= rresp_d;
      rvalid_q     <= rvalid_d;
      bresp_q      <= bresp_d;
      bvalid_q     <= bvalid_d;
    end
  end

  // Byte-lane writes into the array at the write handshake edge.
  always_ff @(posedge clk) begin
    // NOTE: the array is deliberately not reset; contents survive a core
    // reset and a reset port would prevent mapping onto a RAM macro.
    if (mem_we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wstrb[b]) begin
          mem[wr_idx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  assign rdata  = rdata_q;
  assign rresp  = rresp_q;
  assign rvalid = rvalid_q;
  assign bresp  = bresp_q;
  assign bvalid = bvalid_q;

endmodule

// File: tb/tb_ysyx_22041211_sram_slave.sv
// Scoreboard bench for ysyx_22041211_sram_slave: a latency-1 instance covers
// arbitration, byte strobes and range errors; a latency-3 instance covers
// back-pressure and reset during a wait state.
module tb_ysyx_22041211_sram_slave;

  localparam int TIMEOUT = 50;

  logic        clk = 1'b0;
  logic        rst;

  logic [31:0] araddr, awaddr, wdata;
  logic [3:0]  wstrb;

  // Latency-1 instance
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] rdata;
  logic [1:0]  rresp, bresp;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;

  // Latency-3 instance
  logic        arvalid_3, arready_3, rvalid_3, rready_3;
  logic [31:0] rdata_3;
  logic [1:0]  rresp_3, bresp_3;
  logic        awvalid_3, awready_3, wvalid_3, wready_3, bvalid_3, bready_3;

  int          n_vec = 0;
  int          n_err = 0;

  logic [33:0] rd_sb[$];
  logic [1:0]  wr_sb[$];

  always #5 clk = ~clk;

  ysyx_22041211_sram_slave dut (
    .clk(clk), .rst(rst),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  ysyx_22041211_sram_slave #(.RD_LATENCY(3)) dut_l3 (
    .clk(clk), .rst(rst),
    .araddr(araddr), .arvalid(arvalid_3), .arready(arready_3),
    .rdata(rdata_3), .rresp(rresp_3), .rvalid(rvalid_3), .rready(rready_3),
    .awaddr(awaddr), .awvalid(awvalid_3), .awready(awready_3),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid_3), .wready(wready_3),
    .bresp(bresp_3), .bvalid(bvalid_3), .bready(bready_3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Full read on the latency-1 instance; expectation goes through the scoreboard.
  task automatic rd(input logic [31:0] addr, input logic [31:0] exp_data, input logic [1:0] exp_resp);
    int          n;
    logic [33:0] e;
    rd_sb.push_back({exp_resp, exp_data});
    araddr  = addr;
    arvalid = 1'b1;
    rready  = 1'b1;
    #1;
    n = 0;
    while (!arready && n < TIMEOUT) begin @(negedge clk); #1; n++; end
    check("rd_accept", 32'(arready), 32'd1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!rvalid && n < TIMEOUT);
    check("rd_latency", 32'(n), 32'd1);
    e = rd_sb.pop_front();
    check("rd_data", rdata, e[31:0]);
    check("rd_resp", 32'(rresp), 32'(e[33:32]));
    @(negedge clk);
    check("rd_done", 32'(rvalid), 32'd0);
    rready = 1'b0;
  endtask

  // Full write on the latency-1 instance.
  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                    input logic [1:0] exp_resp);
    int         n;
    logic [1:0] e;
    wr_sb.push_back(exp_resp);
    awaddr  = addr;
    wdata   = data;
    wstrb   = strb;
    awvalid = 1'b1;
    wvalid  = 1'b1;
    bready  = 1'b1;
    #1;
    n = 0;
    while (!awready && n < TIMEOUT) begin @(negedge clk); #1; n++; end
    check("wr_accept", {31'd0, awready & wready}, 32'd1);
    @(posedge clk); #1;
    awvalid = 1'b0;
    wvalid  = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!bvalid && n < TIMEOUT);
    check("wr_latency", 32'(n), 32'd1);
    e = wr_sb.pop_front();
    check("wr_resp", 32'(bresp), 32'(e));
    @(negedge clk);
    check("wr_done", 32'(bvalid), 32'd0);
    bready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish within 200000 time units");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          n;
    logic [33:0] e;
    logic [1:0]  eb;

    rst = 1'b0;
    araddr = '0; awaddr = '0; wdata = '0; wstrb = '0;
    arvalid = 0; rready = 0; awvalid = 0; wvalid = 0; bready = 0;
    arvalid_3 = 0; rready_3 = 0; awvalid_3 = 0; wvalid_3 = 0; bready_3 = 0;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_arready", 32'(arready), 32'd0);
    check("rst_awready", {31'd0, awready | wready}, 32'd0);
    check("rst_rvalid",  32'(rvalid), 32'd0);
    check("rst_bvalid",  32'(bvalid), 32'd0);
    check("rst_rdata",   rdata, 32'd0);
    check("rst_resp",    {28'd0, rresp, bresp}, 32'd0);
    rst = 1'b1;

    // Simultaneous requests straight after reset: read wins (last grant = write).
    awaddr = 32'h8000_0000; wdata = 32'hDEAD_BEEF; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    araddr = 32'h7FFF_FFFC; arvalid = 1'b1;
    #1;
    check("arb0_arready", 32'(arready), 32'd1);
    check("arb0_awready", {31'd0, awready | wready}, 32'd0);
    rd(32'h7FFF_FFFC, 32'd0, 2'b10);
    #1;
    check("arb1_awready", 32'(awready), 32'd1);
    check("arb1_arready", 32'(arready), 32'd0);
    wr(32'h8000_0000, 32'hDEAD_BEEF, 4'hF, 2'b00);

    // Both again after the write: read goes next.
    awaddr = 32'h8000_0004; wdata = 32'hFFFF_FFFF; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    araddr = 32'h8000_0000; arvalid = 1'b1;
    #1;
    check("arb2_arready", 32'(arready), 32'd1);
    check("arb2_awready", 32'(awready), 32'd0);
    rd(32'h8000_0000, 32'hDEAD_BEEF, 2'b00);

    // Both again after that read: write goes next.
    arvalid = 1'b1;
    #1;
    check("arb3_awready", 32'(awready), 32'd1);
    check("arb3_arready", 32'(arready), 32'd0);
    wr(32'h8000_0004, 32'hFFFF_FFFF, 4'hF, 2'b00);

    // Read still pending, new write raised: read wins again.
    awaddr = 32'h8000_0004; wdata = 32'h1122_3344; wstrb = 4'b0101;
    awvalid = 1'b1; wvalid = 1'b1;
    #1;
    check("arb4_arready", 32'(arready), 32'd1);
    check("arb4_awready", 32'(awready), 32'd0);
    rd(32'h8000_0000, 32'hDEAD_BEEF, 2'b00);

    // Byte strobes merge over the old word.
    wr(32'h8000_0004, 32'h1122_3344, 4'b0101, 2'b00);
    rd(32'h8000_0004, 32'hFF22_FF44, 2'b00);

    // Out-of-range write leaves word 0 (its aliased index) untouched.
    wr(32'h8000_4000, 32'h1234_5678, 4'hF, 2'b10);
    rd(32'h8000_0000, 32'hDEAD_BEEF, 2'b00);

    // Empty strobe in range: OKAY, no change.
    wr(32'h8000_0004, 32'h0000_0000, 4'b0000, 2'b00);
    rd(32'h8000_0004, 32'hFF22_FF44, 2'b00);

    // Last word of the array; low address bits ignored.
    wr(32'h8000_3FFC, 32'hA5A5_5A5A, 4'hF, 2'b00);
    rd(32'h8000_3FFF, 32'hA5A5_5A5A, 2'b00);

    // Latency-3 instance: preload one word.
    awaddr = 32'h8000_0008; wdata = 32'hCAFE_F00D; wstrb = 4'hF;
    awvalid_3 = 1'b1; wvalid_3 = 1'b1; bready_3 = 1'b1;
    wr_sb.push_back(2'b00);
    #1;
    check("l3_awready", 32'(awready_3), 32'd1);
    @(posedge clk); #1;
    awvalid_3 = 1'b0; wvalid_3 = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!bvalid_3 && n < TIMEOUT);
    eb = wr_sb.pop_front();
    check("l3_bresp", 32'(bresp_3), 32'(eb));
    @(negedge clk);
    bready_3 = 1'b0;

    // Stalled read: rready low for 5 valid cycles, arvalid kept high behind it.
    araddr = 32'h8000_0008; arvalid_3 = 1'b1; rready_3 = 1'b0;
    rd_sb.push_back({2'b00, 32'hCAFE_F00D});
    #1;
    check("l3_arready", 32'(arready_3), 32'd1);
    @(posedge clk); #1;
    n = 0;
    do begin @(negedge clk); n++; end while (!rvalid_3 && n < TIMEOUT);
    check("l3_latency", 32'(n), 32'd3);
    e = rd_sb.pop_front();
    for (int i = 0; i < 5; i++) begin
      check("l3_hold_rvalid", 32'(rvalid_3), 32'd1);
      check("l3_hold_rdata", rdata_3, e[31:0]);
      check("l3_hold_arready", 32'(arready_3), 32'd0);
      @(negedge clk);
    end
    check("l3_rresp", 32'(rresp_3), 32'(e[33:32]));
    rready_3 = 1'b1;
    #1;
    check("l3_arready_at_rready", 32'(arready_3), 32'd0);
    @(negedge clk);
    check("l3_rvalid_after", 32'(rvalid_3), 32'd0);
    check("l3_arready_after", 32'(arready_3), 32'd1);
    rready_3 = 1'b0;

    // That pending read is accepted now; reset it while in its wait state.
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("l3_rst_arready0", 32'(arready_3), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("l3_rst_rvalid", 32'(rvalid_3), 32'd0);
      check("l3_rst_arready", 32'(arready_3), 32'd0);
    end
    rst = 1'b1;

    // Fresh read after reset returns the preserved word.
    rd_sb.push_back({2'b00, 32'hCAFE_F00D});
    #1;
    check("l3_fresh_arready", 32'(arready_3), 32'd1);
    @(posedge clk); #1;
    arvalid_3 = 1'b0;
    rready_3  = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!rvalid_3 && n < TIMEOUT);
    check("l3_fresh_latency", 32'(n), 32'd3);
    e = rd_sb.pop_front();
    check("l3_fresh_rdata", rdata_3, e[31:0]);
    check("l3_fresh_rresp", 32'(rresp_3), 32'(e[33:32]));
    @(negedge clk);
    check("l3_fresh_done", 32'(rvalid_3), 32'd0);
    rready_3 = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ysyx_22041211_sram_slave.md
Name: ysyx_22041211_sram_slave

Overview:
Memory-side responder for the core's instruction-fetch and load/store requests. It is the target end of the AXI4-Lite-subset handshake that the IFU and LSU issue as initiators. It holds a word-addressed storage array and returns read data and write acknowledgements after a fixed or pseudo-random number of wait states. It sits outside the core, in the simulation top, behind the bus arbiter, and is the single memory target for both the fetch and the data path.

Parameters:
ADDR_WIDTH, 32, address bus width
DATA_WIDTH, 32, data bus width; fixed at 32, one byte strobe per byte
DEPTH_LOG2, 12, log2 of the number of 32-bit words in the array
BASE_ADDR, 32'h8000_0000, byte address of word 0
RD_LATENCY, 1, cycles from the AR handshake to the first cycle rvalid is high; must be >=1
WR_LATENCY, 1, cycles from the AW/W handshake to the first cycle bvalid is high; must be >=1
RAND_EN, 0, when 1, adds 0-7 extra wait cycles per transaction, taken from an LFSR

Ports:
clk  in  1  clock; all state changes on the rising edge
rst  in  1  reset, synchronous, active-low
araddr  in  ADDR_WIDTH  read address
arvalid  in  1  read address valid
arready  out  1  read address accepted
rdata  out  32  read data
rresp  out  2  read response: 00 OKAY, 10 SLVERR
rvalid  out  1  read response valid
rready  in  1  initiator accepts read response
awaddr  in  ADDR_WIDTH  write address
awvalid  in  1  write address valid
awready  out  1  write address accepted
wdata  in  32  write data
wstrb  in  4  byte enables; bit i covers wdata[8i+7:8i]
wvalid  in  1  write data valid
wready  out  1  write data accepted
bresp  out  2  write response: 00 OKAY, 10 SLVERR
bvalid  out  1  write response valid
bready  in  1  initiator accepts write response

Behaviour:
- Reset (rst==0 sampled at an edge): state goes to IDLE. arready, awready, wready, rvalid and bvalid are 0. rdata=0, rresp=0, bresp=0. LFSR=8'hA5. last_grant=WRITE. Any transaction in flight is discarded with no response. The storage array is not cleared.
- FSM states: IDLE, RD_WAIT, RD_RESP, WR_WAIT, WR_RESP.
- IDLE readies are combinational:
  - arready = (state==IDLE) & grant_rd.
  - awready = wready = (state==IDLE) & grant_wr.
- Grant rules:
  - Only arvalid: grant_rd.
  - Only (awvalid & wvalid): grant_wr.
  - Both requests present: grant the side opposite last_grant (round-robin).
  - awvalid without wvalid, or wvalid without awvalid: no write grant. AW and W are always accepted in the same cycle.
- Range check: in_range = (addr - BASE_ADDR) < 4*2^DEPTH_LOG2, computed as an unsigned ADDR_WIDTH-bit subtraction. Word index = (addr - BASE_ADDR)[DEPTH_LOG2+1:2]. addr[1:0] is ignored.
- Read handshake (arvalid & arready): latch the response (mem[index] with OKAY, or 0 with SLVERR if out of range). Load the wait counter with RD_LATENCY-1 plus extra, set last_grant=READ, and go to RD_WAIT, or straight to RD_RESP if the counter is 0.
- Write handshake: for each set wstrb bit, write that byte lane into mem[index] at this edge. Out of range, or wstrb==0: no array change. Out of range gives SLVERR; wstrb==0 in range gives OKAY. Set last_grant=WRITE and go to WR_WAIT or WR_RESP by the same counter rule.
- A read accepted on the cycle after a write handshake returns the new data (write-then-read coherence).
- RD_WAIT / WR_WAIT: decrement the counter each cycle; at 0, move to the matching RESP state.
- RD_RESP: rvalid=1, with rdata and rresp held stable until rvalid & rready. On the handshake edge: rvalid=0, return to IDLE. No new request is accepted on that same edge, so the next arready is at the earliest the following cycle. WR_RESP behaves the same with bvalid and bready.
- Latency: with RAND_EN=0, rvalid first rises exactly RD_LATENCY cycles after the AR handshake edge (1 means the next cycle). Write latency is the same with WR_LATENCY.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, advances every cycle regardless of RAND_EN. extra = RAND_EN ? lfsr[2:0] : 0, sampled at the handshake edge.
- rready or bready held high before valid: the response completes in its first valid cycle.
- rst low in any state: applies next edge; outputs take reset values that cycle.

Test Plan:
- RD_LATENCY=1: preload mem[0]=32'hDEAD_BEEF; araddr=32'h8000_0000 with arvalid and rready held 1 -> arready high the same cycle, rvalid=1 with rdata=DEADBEEF and rresp=00 exactly 1 cycle later, rvalid=0 the cycle after.
- Write awaddr=32'h8000_0004, wdata=32'h1122_3344, wstrb=4'b0101 over old 32'hFFFF_FFFF; then read the same address -> bresp=00, rdata=32'hFF22_FF44.
- araddr=32'h7FFF_FFFC and awaddr=32'h8000_4000 (DEPTH_LOG2=12) -> rresp=10 with rdata=0; bresp=10; array unchanged.
- arvalid, awvalid and wvalid all raised in the same cycle just after reset -> read granted first, write granted on the next IDLE. Raising both again -> read is granted after that write (round-robin holds).
- RD_LATENCY=3 with rready held 0 for 5 cycles -> rvalid rises 3 cycles after AR, rdata stays stable for 5 cycles, and arready stays 0 until the cycle after rready.
- rst driven low during RD_WAIT -> rvalid never asserts, arready=0 while rst is low, and a fresh read after reset returns correct data.
